// File: rtl/pulse_meas_pkg.sv
// pulse_meas_pkg: shared types for the multi-channel pulse measurement block.
// Holds the measurement mode enum, the per-channel state enum and the mode decode helper.
package pulse_meas_pkg;

    typedef enum logic [1:0] {
        MODE_HIGH   = 2'b00,
        MODE_LOW    = 2'b01,
        MODE_PERIOD = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_COUNT,
        ST_HOLD
    } ch_state_t;

    // Raw mode 11 has no meaning of its own and measures high width.
    function automatic mode_t decode_mode(input logic [1:0] m);
        return (m == 2'b01) ? MODE_LOW : (m == 2'b10) ? MODE_PERIOD : MODE_HIGH;
    endfunction

endpackage

// File: rtl/pulse_meas_ch.sv
// pulse_meas_ch: one measurement channel (synchronizer, edge detect, FSM, saturating counter).
// Ports: clk, reset (async, active-high), enable (arm/abort), mode (raw 2-bit mode),
//        sig_in (async input), rel (result taken, leave HOLD), hold (result waiting),
//        busy (not IDLE), dur/ovf (captured result and saturation flag).
module pulse_meas_ch
    import pulse_meas_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             sig_in,
    input  logic             rel,
    output logic             hold,
    output logic             busy,
    output logic [CNT_W-1:0] dur,
    output logic             ovf
);

    logic s1, s2, s3, rise, fall;
    logic start_e, end_e;
    logic [CNT_W-1:0] cnt;
    logic cnt_ovf;
    mode_t md;
    ch_state_t state, state_nx;

    assign start_e = (md == MODE_LOW) ? fall : rise;
    assign end_e   = (md == MODE_HIGH) ? fall : rise;
    assign hold    = state == ST_HOLD;
    assign busy    = state != ST_IDLE;

    // End edge is tested before start edge in COUNT, so a shared period edge only ends.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:       state_nx = enable ? ST_WAIT_START : ST_IDLE;
            ST_WAIT_START: state_nx = !enable ? ST_IDLE : start_e ? ST_COUNT : ST_WAIT_START;
            ST_COUNT:      state_nx = !enable ? ST_IDLE : end_e ? ST_HOLD : ST_COUNT;
            ST_HOLD:       state_nx = !rel ? ST_HOLD : enable ? ST_WAIT_START : ST_IDLE;
            default:       state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            state   <= ST_IDLE;
            md      <= MODE_HIGH;
            cnt     <= '0;
            cnt_ovf <= 1'b0;
            dur     <= '0;
            ovf     <= 1'b0;
        end else begin
            s1    <= sig_in;
            s2    <= s1;
            s3    <= s2;
            rise  <= s2 & ~s3;
            fall  <= ~s2 & s3;
            state <= state_nx;
            if (state == ST_IDLE && state_nx == ST_WAIT_START)
                md <= decode_mode(mode);
            if (state == ST_WAIT_START && state_nx == ST_COUNT) begin
                cnt     <= CNT_W'(1);
                cnt_ovf <= 1'b0;
            end else if (state == ST_COUNT && state_nx == ST_COUNT) begin
                if (&cnt)
                    cnt_ovf <= 1'b1;
                else
                    cnt <= cnt + 1'b1;
            end
            if (state == ST_COUNT && state_nx == ST_HOLD) begin
                dur <= cnt;
                ovf <= cnt_ovf;
            end
        end
    end

endmodule

// File: rtl/pulse_meas_mc.sv
// pulse_meas_mc: N_CH-channel pulse width / period meter with a round-robin result port.
// Ports: clk, reset (async, active-high), enable (global arm), mode (00 high, 01 low, 10 period),
//        sig_in (one async bit per channel), res_valid/res_ready handshake with res_ch, res_dur,
//        res_ovf payload, busy (per-channel activity).
module pulse_meas_mc
    import pulse_meas_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 12,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [N_CH-1:0]  sig_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CH_W-1:0]  res_ch,
    output logic [CNT_W-1:0] res_dur,
    output logic             res_ovf,
    output logic [N_CH-1:0]  busy
);

    logic [N_CH-1:0] hold, rel, pend, ovf;
    logic [CNT_W-1:0] dur [N_CH];
    logic [CH_W-1:0] ptr, gidx, idx;
    logic found;

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            assign rel[i]  = res_valid && res_ready && res_ch == CH_W'(i);
            // The channel being presented stays in HOLD until accepted; never grant it twice.
            assign pend[i] = hold[i] && !(res_valid && res_ch == CH_W'(i));
            pulse_meas_ch #(.CNT_W(CNT_W)) u_ch (
                .clk    (clk),
                .reset  (reset),
                .enable (enable),
                .mode   (mode),
                .sig_in (sig_in[i]),
                .rel    (rel[i]),
                .hold   (hold[i]),
                .busy   (busy[i]),
                .dur    (dur[i]),
                .ovf    (ovf[i])
            );
        end
    endgenerate

    // ptr holds the first index to consider, i.e. one past the last grant.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = CH_W'((int'(ptr) + k) % N_CH);
            if (!found && pend[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_dur   <= '0;
            res_ovf   <= 1'b0;
            ptr       <= '0;
        end else if (!res_valid || res_ready) begin
            res_valid <= found;
            if (found) begin
                res_ch  <= gidx;
                res_dur <= dur[gidx];
                res_ovf <= ovf[gidx];
                ptr     <= (gidx == CH_W'(N_CH - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_meas_mc.sv
// tb_pulse_meas_mc: directed self-checking bench for pulse_meas_mc (4 ch / 12 bit and 4 ch / 4 bit).
module tb_pulse_meas_mc;

    typedef struct packed {
        logic [1:0]  ch;
        logic [11:0] dur;
        logic        ovf;
    } rec_t;

    logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, res_ready = 1'b0, ready_b = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [3:0]  sig_in = 4'h0, sig_b = 4'h0;
    logic        res_valid, res_ovf, valid_b, ovf_b;
    logic [1:0]  res_ch, ch_b;
    logic [11:0] res_dur;
    logic [3:0]  dur_b, busy, busy_b;
    int          checks = 0, errors = 0;
    rec_t        q[$], q4[$];

    always #5 clk = ~clk;

    pulse_meas_mc #(.N_CH(4), .CNT_W(12)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .sig_in(sig_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_dur(res_dur),
        .res_ovf(res_ovf), .busy(busy)
    );

    pulse_meas_mc #(.N_CH(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .sig_in(sig_b),
        .res_valid(valid_b), .res_ready(ready_b), .res_ch(ch_b), .res_dur(dur_b),
        .res_ovf(ovf_b), .busy(busy_b)
    );

    always @(negedge clk) begin
        if (res_valid && res_ready) q.push_back(rec_t'{res_ch, res_dur, res_ovf});
        if (valid_b && ready_b) q4.push_back(rec_t'{ch_b, 12'(dur_b), ovf_b});
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setup(input logic [1:0] m, input logic [3:0] init);
        reset = 1'b1; enable = 1'b0; res_ready = 1'b0; sig_in = init; sig_b = 4'h0; mode = m;
        tick(2);
        reset = 1'b0;
        tick(4);
        enable = 1'b1;
        tick(2);
        q.delete();
        q4.delete();
    endtask

    task automatic wait_valid(input int lim, output bit ok);
        int n = 0;
        ok = res_valid;
        while (!ok && n < lim) begin
            tick();
            n++;
            ok = res_valid;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", res_valid); end
        checks++; if (res_ch !== 2'd0) begin errors++; $display("FAIL rst_ch got %0d exp 0", res_ch); end
        checks++; if (res_dur !== 12'd0) begin errors++; $display("FAIL rst_dur got %0d exp 0", res_dur); end
        checks++; if (res_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", res_ovf); end
        checks++; if (busy !== 4'h0) begin errors++; $display("FAIL rst_busy got %h exp 0", busy); end
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_high();
        setup(2'b00, 4'h0);
        res_ready = 1'b1;
        checks++; if (busy !== 4'hF) begin errors++; $display("FAIL busy_armed got %h exp f", busy); end
        sig_in[0] = 1'b1; tick(10); sig_in[0] = 1'b0;
        tick(15);
        checks++; if (q.size() != 1) begin errors++; $display("FAIL high_count got %0d exp 1", q.size()); end
        if (q.size() > 0) begin
            checks++; if (q[0] !== rec_t'{2'd0, 12'd10, 1'b0}) begin errors++;
                $display("FAIL high_result got ch%0d dur%0d ovf%b exp ch0 dur10 ovf0", q[0].ch, q[0].dur, q[0].ovf); end
        end
    endtask

    task automatic test_low();
        setup(2'b01, 4'b0100);
        res_ready = 1'b1;
        sig_in[2] = 1'b0; tick(7); sig_in[2] = 1'b1;
        tick(15);
        checks++; if (q.size() != 1) begin errors++; $display("FAIL low_count got %0d exp 1", q.size()); end
        if (q.size() > 0) begin
            checks++; if (q[0] !== rec_t'{2'd2, 12'd7, 1'b0}) begin errors++;
                $display("FAIL low_result got ch%0d dur%0d ovf%b exp ch2 dur7 ovf0", q[0].ch, q[0].dur, q[0].ovf); end
        end
    endtask

    task automatic test_period();
        setup(2'b10, 4'h0);
        res_ready = 1'b1;
        sig_in[1] = 1'b1; tick(5); sig_in[1] = 1'b0; tick(20);
        sig_in[1] = 1'b1; tick(5); sig_in[1] = 1'b0;
        tick(15);
        checks++; if (q.size() != 1) begin errors++; $display("FAIL period_count got %0d exp 1", q.size()); end
        if (q.size() > 0) begin
            checks++; if (q[0] !== rec_t'{2'd1, 12'd25, 1'b0}) begin errors++;
                $display("FAIL period_result got ch%0d dur%0d ovf%b exp ch1 dur25 ovf0", q[0].ch, q[0].dur, q[0].ovf); end
        end
    endtask

    task automatic test_ovf();
        setup(2'b00, 4'h0);
        sig_b[0] = 1'b1; tick(40); sig_b[0] = 1'b0;
        tick(15);
        sig_b[1] = 1'b1; tick(14); sig_b[1] = 1'b0;
        tick(15);
        checks++; if (q4.size() != 2) begin errors++; $display("FAIL ovf_count got %0d exp 2", q4.size()); end
        if (q4.size() > 1) begin
            checks++; if (q4[0] !== rec_t'{2'd0, 12'd15, 1'b1}) begin errors++;
                $display("FAIL ovf_sat got ch%0d dur%0d ovf%b exp ch0 dur15 ovf1", q4[0].ch, q4[0].dur, q4[0].ovf); end
            checks++; if (q4[1] !== rec_t'{2'd1, 12'd14, 1'b0}) begin errors++;
                $display("FAIL ovf_below got ch%0d dur%0d ovf%b exp ch1 dur14 ovf0", q4[1].ch, q4[1].dur, q4[1].ovf); end
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL ovf_main_quiet got %0d exp 0", q.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        setup(2'b00, 4'h0);
        sig_in = 4'hF; tick(6); sig_in = 4'h0;
        wait_valid(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got valid 0 exp 1"); end
        tick(1);
        checks++; if (busy !== 4'hF) begin errors++; $display("FAIL b2b_busy got %h exp f", busy); end
        for (int c = 0; c < 5; c++) begin
            checks++; if ({res_valid, res_ch, res_dur, res_ovf} !== {1'b1, 2'd0, 12'd6, 1'b0}) begin errors++;
                $display("FAIL b2b_stall%0d got v%b ch%0d dur%0d ovf%b exp v1 ch0 dur6 ovf0", c, res_valid, res_ch, res_dur, res_ovf); end
            tick(1);
        end
        res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checks++; if ({res_valid, res_ch, res_dur} !== {1'b1, 2'(c), 12'd6}) begin errors++;
                $display("FAIL b2b_seq%0d got v%b ch%0d dur%0d exp v1 ch%0d dur6", c, res_valid, res_ch, res_dur, c); end
            tick(1);
        end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", res_valid); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        setup(2'b00, 4'h0);
        res_ready = 1'b1;
        sig_in[3] = 1'b1; tick(8);
        checks++; if (busy[3] !== 1'b1) begin errors++; $display("FAIL en_counting got %b exp 1", busy[3]); end
        enable = 1'b0;
        tick(1);
        checks++; if (busy !== 4'h0) begin errors++; $display("FAIL en_abort_busy got %h exp 0", busy); end
        sig_in[3] = 1'b0;
        tick(10);
        checks++; if (q.size() != 0 || res_valid !== 1'b0) begin errors++;
            $display("FAIL en_no_result got %0d results valid %b exp 0", q.size(), res_valid); end
        setup(2'b00, 4'h0);
        sig_in[0] = 1'b1; tick(3); sig_in[0] = 1'b0;
        wait_valid(30, ok);
        enable = 1'b0;
        tick(2);
        checks++; if ({res_valid, res_ch, res_dur} !== {1'b1, 2'd0, 12'd3}) begin errors++;
            $display("FAIL en_hold_kept got v%b ch%0d dur%0d exp v1 ch0 dur3", res_valid, res_ch, res_dur); end
        checks++; if (busy !== 4'b0001) begin errors++; $display("FAIL en_hold_busy got %h exp 1", busy); end
        res_ready = 1'b1;
        tick(1);
        checks++; if (res_valid !== 1'b0 || busy !== 4'h0) begin errors++;
            $display("FAIL en_hold_taken got v%b busy %h exp v0 busy 0", res_valid, busy); end
    endtask

    task automatic test_reset_handshake();
        bit ok;
        setup(2'b00, 4'h0);
        sig_in[1] = 1'b1; tick(4); sig_in[1] = 1'b0;
        wait_valid(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rsths_timeout got valid 0 exp 1"); end
        reset = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rsths_valid got %b exp 0", res_valid); end
        checks++; if (busy !== 4'h0 || res_dur !== 12'd0) begin errors++;
            $display("FAIL rsths_state got busy %h dur %0d exp 0 0", busy, res_dur); end
        tick(2);
        reset = 1'b0;
        res_ready = 1'b1;
        tick(10);
        checks++; if (q.size() != 0 || res_valid !== 1'b0) begin errors++;
            $display("FAIL rsths_discard got %0d results valid %b exp 0", q.size(), res_valid); end
    endtask

    initial begin
        test_reset();
        test_high();
        test_low();
        test_period();
        test_ovf();
        test_back_to_back();
        test_enable_drop();
        test_reset_handshake();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
